instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-cycle CPU. Holds the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each instruction downstream with valid/ready. It extracts the 16-bit immediate and the zero/sign-extend select that feed the immediate extender. It consumes the extender's 32-bit result to compute branch redirect targets.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request; high in FETCH and FLUSH.
- imem_addr  out  32  fetch address; stable while imem_req is high.
- imem_ack  in  1  memory response strobe; sampled only while imem_req is high; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word; valid when imem_ack is high.
- instr  out  32  registered instruction.
- pc_out  out  32  address of instr.
- imm16  out  16  instr[15:0].
- sel_zero  out  1  1 when instr[31:26] is 6'h0C, 6'h0D or 6'h0E (andi/ori/xori); else 0.
- instr_valid  out  1  instr, pc_out, imm16 and sel_zero are valid.
- instr_ready  in  1  downstream accepts in the cycle where instr_valid && instr_ready.
- redirect  in  1  one-cycle redirect strobe from execute.
- redirect_is_jump  in  1  1 = jump, 0 = taken branch.
- redirect_pc  in  32  PC of the redirecting instruction.
- imm32  in  32  extended immediate of the redirecting branch.
- jidx  in  26  jump index of the redirecting jump.

## Operation
- States: IDLE, FETCH, HOLD, FLUSH. Internal registers: pc, req_addr.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next edge; req_addr <= pc.
- FETCH: imem_req=1 and imem_addr=req_addr.
  - On ack: instr <= imem_rdata, pc_out <= req_addr, instr_valid <= 1, next state HOLD.
- HOLD: imem_req=0 and instr_valid=1.
  - On accept: pc <= pc+4, req_addr <= pc+4, instr_valid <= 0, next state FETCH.
- FLUSH: imem_req=1 and imem_addr=req_addr (stale address).
  - Waits for ack, discards rdata, then req_addr <= pc and next state FETCH.
- Redirect has priority over every other event in every state. It loads pc with the target:
  - Branch target: redirect_pc + 4 + (imm32 << 2), modulo 2^32.
  - Jump target: {(redirect_pc+4)[31:28], jidx, 2'b00}.
- Redirect per state:
  - In HOLD, including the same cycle as instr_ready: instr_valid <= 0, the held instruction is dropped (not accepted), req_addr <= target, next state FETCH.
  - In FETCH with imem_ack in the same cycle: rdata is discarded, req_addr <= target, next state FETCH.
  - In FETCH without ack: next state FLUSH; req_addr keeps the old address so the in-flight request completes unchanged.
  - In FLUSH: pc updates to the newest target and the state stays FLUSH.
  - In IDLE: pc <= target.
- PC wrap: 32'hFFFF_FFFC + 4 gives 0; no fault.
- imm16 and sel_zero are registered with instr, so they never change while instr_valid is high.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=0, pc_out=RESET_PC, imm16=0, sel_zero=0, instr_valid=0, state IDLE.
- Reset asserted mid-transaction abandons any outstanding request. The memory side must tolerate a dropped req.
- First imem_req is high in the 2nd cycle after rst falls.
- Ack in cycle N gives instr_valid=1 in cycle N+1.
- Accept in cycle M gives imem_req=1 for pc+4 in cycle M+1.
- With zero-wait memory and instr_ready tied high, one instruction is delivered every 2 cycles.
- Redirect in cycle R (not in FLUSH-pending) gives imem_req=1 with imem_addr=target in cycle R+1.
- imem_addr never changes while imem_req=1 and imem_ack=0.

## Test plan
- Reset, RESET_PC=0, zero-wait memory, instr_ready=1:
  - imem_addr sequence 0, 4, 8 on cycles 2, 4, 6.
  - instr_valid pulses carry the matching rdata and pc_out.
- imem_rdata=32'h3421_8000 (ori):
  - imm16=16'h8000, sel_zero=1.
  - Then 32'h2021_FFFF (addi): sel_zero=0, imm16=16'hFFFF.
- instr_ready=0 for 5 cycles in HOLD:
  - instr, pc_out and instr_valid stay stable; imem_req=0.
  - On release, the next fetch address is pc+4.
- Branch redirect, redirect_pc=32'h100, imm32=32'hFFFF_FFFE, asserted together with instr_ready in HOLD:
  - Held instruction dropped; next imem_addr=32'h0FC.
- Jump redirect during FETCH with 3-cycle-late ack, redirect_pc=32'h1000_0040, jidx=26'h10:
  - State goes FLUSH and old imem_addr held until ack; stale rdata never reaches instr_valid.
  - Next imem_addr=32'h1000_0040.
- pc=32'hFFFF_FFFC accepted:
  - Next imem_addr=32'h0000_0000.
- rst asserted while in FLUSH:
  - Next cycle: imem_req=0, instr_valid=0, pc_out=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage for the single-cycle CPU. Holds the program counter,
// fetches 32-bit instruction words from instruction memory over a req/ack
// handshake and presents each word downstream with a valid/ready handshake.
// It also pulls out the 16-bit immediate and the zero/sign-extend select that
// feed the immediate extender, and turns the extender's result into branch
// redirect targets.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   rst               synchronous active-high reset
//   imem_req          fetch request to instruction memory
//   imem_addr         fetch address, held stable until the request is acked
//   imem_ack          memory response strobe (only looked at while imem_req)
//   imem_rdata        instruction word, valid with imem_ack
//   instr             registered instruction word
//   pc_out            address of instr
//   imm16             instr[15:0]
//   sel_zero          1 for andi/ori/xori (zero-extend), else 0
//   instr_valid       instr/pc_out/imm16/sel_zero are valid
//   instr_ready       downstream accepts when instr_valid && instr_ready
//   redirect          one-cycle redirect strobe from execute
//   redirect_is_jump  1 = jump, 0 = taken branch
//   redirect_pc       PC of the redirecting instruction
//   imm32             extended immediate of the redirecting branch
//   jidx              jump index of the redirecting jump
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [15:0] imm16,
   output logic        sel_zero,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic        redirect_is_jump,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] imm32,
   input  logic [25:0] jidx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_addr;

   logic [31:0] link_pc;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        rdata_sel_zero;

   // The address presented to memory is always the registered request
   // address, so it can only move on a clock edge and never glitches while
   // a request is outstanding.
   assign imem_addr = req_addr;

   // Redirect target calculation. Both branch and jump targets are relative
   // to the instruction after the redirecting one; branches add the word
   // offset, jumps splice the index under the top nibble. All arithmetic
   // wraps modulo 2^32.
   always_comb begin
      link_pc        = redirect_pc + 32'd4;
      branch_target  = link_pc + (imm32 << 2);
      jump_target    = {link_pc[31:28], jidx, 2'b00};
      target         = redirect_is_jump ? jump_target : branch_target;
      pc_plus4       = pc + 32'd4;
      rdata_sel_zero = (imem_rdata[31:26] == 6'h0C) ||
                       (imem_rdata[31:26] == 6'h0D) ||
                       (imem_rdata[31:26] == 6'h0E);
   end

   // Fetch controller. Redirect beats every other event in every state.
   // A redirect that arrives while a request is in flight without its ack
   // cannot retarget that request (the address must stay stable), so the
   // controller parks in FLUSH until the stale word comes back and throws it
   // away, then refetches from the new pc. imem_req is registered here next
   // to the state so it is high exactly in FETCH and FLUSH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         imem_req    <= 1'b0;
         instr       <= 32'd0;
         pc_out      <= RESET_PC;
         imm16       <= 16'd0;
         sel_zero    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= FETCH;
               imem_req <= 1'b1;
               if (redirect) begin
                  pc       <= target;
                  req_addr <= target;
               end else begin
                  req_addr <= pc;
               end
            end

            FETCH: begin
               if (redirect) begin
                  pc <= target;
                  if (imem_ack) begin
                     req_addr <= target;
                  end else begin
                     state <= FLUSH;
                  end
               end else if (imem_ack) begin
                  instr       <= imem_rdata;
                  imm16       <= imem_rdata[15:0];
                  sel_zero    <= rdata_sel_zero;
                  pc_out      <= req_addr;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= HOLD;
               end
            end

            HOLD: begin
               if (redirect) begin
                  pc          <= target;
                  req_addr    <= target;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end else if (instr_ready) begin
                  pc          <= pc_plus4;
                  req_addr    <= pc_plus4;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end
            end

            FLUSH: begin
               if (redirect) begin
                  pc <= target;
               end else if (imem_ack) begin
                  req_addr <= pc;
                  state    <= FETCH;
               end
            end

            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A transaction-level reference model
// tracks the outstanding memory request, whether its data will be thrown
// away, the held instruction and the pc; every cycle the DUT outputs are
// compared with it. Directed sequences walk the documented scenarios, then a
// long randomized phase mixes acks, stalls, redirects and resets.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [15:0] imm16;
   logic        sel_zero;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic        redirect_is_jump;
   logic [31:0] redirect_pc;
   logic [31:0] imm32;
   logic [25:0] jidx;

   int compare_count;
   int mismatch_count;

   // Reference model state, in transaction terms
   logic        m_started;
   logic        m_busy;
   logic        m_stale;
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   logic [31:0] m_instr;
   logic [31:0] m_pcout;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rdata       (imem_rdata),
      .instr            (instr),
      .pc_out           (pc_out),
      .imm16            (imm16),
      .sel_zero         (sel_zero),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .redirect         (redirect),
      .redirect_is_jump (redirect_is_jump),
      .redirect_pc      (redirect_pc),
      .imm32            (imm32),
      .jidx             (jidx)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Redirect target from the architectural definition
   function automatic logic [31:0] targetOf(input logic is_jump, input logic [31:0] rpc,
                                            input logic [31:0] imm, input logic [25:0] idx);
      logic [31:0] nxt;
      nxt = rpc + 32'd4;
      if (is_jump) return (nxt & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
      return nxt + imm * 32'd4;
   endfunction

   // Advance the model by one clock edge using the inputs sampled at it
   task automatic modelStep();
      logic [31:0] tgt;
      tgt = targetOf(redirect_is_jump, redirect_pc, imm32, jidx);
      if (rst) begin
         m_started = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
         m_pc = 32'd0; m_addr = 32'd0; m_instr = 32'd0; m_pcout = 32'd0;
      end else if (!m_started) begin
         m_started = 1'b1;
         if (redirect) m_pc = tgt;
         m_addr = m_pc;
         m_busy = 1'b1;
      end else if (m_busy && m_stale) begin
         if (redirect) m_pc = tgt;
         else if (imem_ack) begin
            m_stale = 1'b0;
            m_addr  = m_pc;
         end
      end else if (m_busy) begin
         if (redirect) begin
            m_pc = tgt;
            if (imem_ack) m_addr = tgt;
            else m_stale = 1'b1;
         end else if (imem_ack) begin
            m_instr = imem_rdata;
            m_pcout = m_addr;
            m_valid = 1'b1;
            m_busy  = 1'b0;
         end
      end else begin
         if (redirect) begin
            m_pc = tgt; m_addr = tgt; m_valid = 1'b0; m_busy = 1'b1;
         end else if (instr_ready) begin
            m_pc = m_pc + 32'd4; m_addr = m_pc; m_valid = 1'b0; m_busy = 1'b1;
         end
      end
   endtask

   // Compare all outputs against the model
   task automatic checkModel();
      logic [5:0] op;
      op = m_instr[31:26];
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
      if (m_busy) checkOutput("imem_addr", imem_addr, m_addr);
      checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      checkOutput("instr", instr, m_instr);
      checkOutput("pc_out", pc_out, m_pcout);
      checkOutput("imm16", {16'd0, imm16}, m_instr % 32'h1_0000);
      checkOutput("sel_zero", {31'd0, sel_zero},
                  {31'd0, (op >= 6'd12 && op <= 6'd14)});
   endtask

   // Drive one cycle of inputs, clock it, then check half a cycle later
   task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                input logic ready, input logic redir,
                                input logic is_jump, input logic [31:0] rpc,
                                input logic [31:0] imm, input logic [25:0] idx);
      imem_ack         = ack;
      imem_rdata       = rdata;
      instr_ready      = ready;
      redirect         = redir;
      redirect_is_jump = is_jump;
      redirect_pc      = rpc;
      imm32            = imm;
      jidx             = idx;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkModel();
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      compare_count  = 0;
      mismatch_count = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_addr", imem_addr, 32'd0);
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_instr", instr, 32'd0);

      // Zero-wait memory, always ready: fetches at 0, 4, 8 every other cycle
      rst = 1'b0;
      applyStimulus(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("first_req", {31'd0, imem_req}, 32'd1);
      checkOutput("first_addr", imem_addr, 32'd0);
      for (int k = 1; k <= 2; k++) begin
         applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
         checkOutput("zw_valid", {31'd0, instr_valid}, 32'd1);
         applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
         checkOutput("zw_addr", imem_addr, 32'(4 * k));
      end

      // ori then addi immediates
      applyStimulus(1'b1, 32'h3421_8000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("ori_imm16", {16'd0, imm16}, 32'h8000);
      checkOutput("ori_sel", {31'd0, sel_zero}, 32'd1);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      applyStimulus(1'b1, 32'h2021_FFFF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("addi_imm16", {16'd0, imm16}, 32'hFFFF);
      checkOutput("addi_sel", {31'd0, sel_zero}, 32'd0);

      // Five stalled cycles in HOLD, then release
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'($urandom), $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
         checkOutput("stall_instr", instr, 32'h2021_FFFF);
         checkOutput("stall_pc", pc_out, 32'h0000_000C);
      end
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("release_addr", imem_addr, 32'h10);

      // Branch redirect together with accept in HOLD
      applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFE, 26'd0);
      checkOutput("br_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("br_addr", imem_addr, 32'h0FC);

      // Jump redirect during FETCH, ack three cycles later
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h1000_0040, 32'd0, 26'h10);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("flush_hold_addr", imem_addr, 32'h0FC);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("flush_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("jmp_addr", imem_addr, 32'h1000_0040);
      applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("jmp_pc_out", pc_out, 32'h1000_0040);

      // PC wrap from the top of the address space
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hF000_0000, 32'd0, 26'h3FF_FFFF);
      checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("wrap_addr", imem_addr, 32'h0);

      // Reset while in FLUSH
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h40, 32'd3, 26'd0);
      rst = 1'b1;
      applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
      checkOutput("flush_rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("flush_rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("flush_rst_pc_out", pc_out, 32'd0);
      rst = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         applyStimulus(1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 9) == 0),
                       1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)),
                       26'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compare_count, mismatch_count);
      $finish;
   end

endmodule
